// File: rtl/stack_arbiter_pkg.sv
// Shared definitions for the two-requester stack arbiter: FSM states, op codes,
// default sizes and the reject rule used wherever an op is judged against the stack flags.
package stack_arbiter_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 1;

  localparam logic OP_POP  = 1'b0;
  localparam logic OP_PUSH = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  // A push cannot land on a full stack and a pop cannot come from an empty one.
  function automatic logic op_rejected(input logic op, input logic full, input logic empty);
    if (op == OP_PUSH) begin
      return full;
    end else begin
      return empty;
    end
  endfunction

endpackage

// File: rtl/stack_arbiter_if.sv
// Requester and stack-side signals of the arbiter. The arbiter takes the slave view;
// the environment (requesters plus the external stack) takes the master view.
interface stack_arbiter_if #(
  parameter int WIDTH = stack_arbiter_pkg::DEF_WIDTH
);

  logic             req0;
  logic             req1;
  logic             op0;
  logic             op1;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic             done0;
  logic             done1;
  logic             err;
  logic [WIDTH-1:0] dout;
  logic             stk_c;
  logic             stk_en;
  logic [WIDTH-1:0] stk_push;
  logic [WIDTH-1:0] stk_peek;
  logic             stk_full;
  logic             stk_empty;

  modport master (
    output req0, req1, op0, op1, din0, din1, stk_peek, stk_full, stk_empty,
    input  done0, done1, err, dout, stk_c, stk_en, stk_push
  );

  modport slave (
    input  req0, req1, op0, op1, din0, din1, stk_peek, stk_full, stk_empty,
    output done0, done1, err, dout, stk_c, stk_en, stk_push
  );

endinterface

// File: rtl/stack_arbiter_rr_pick.sv
// Two-way round-robin chooser: a lone request wins, a tie goes to the side not served last.
module rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic win
);

  // Winner index from the current requests and the last-served pointer.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = ~last;
    end else if (req1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Serialises push/pop requests from two requesters onto one external stack,
// one operation at a time through IDLE -> ARB -> EXEC -> RESP.
module stack_arbiter import stack_arbiter_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          clr,
  stack_arbiter_if.slave bus
);

  if (WIDTH < 1 || DEPTH < 1) begin : g_param_check
    $error("stack_arbiter: WIDTH and DEPTH must both be at least 1");
  end

  state_t           state_r;
  logic             last_r;
  logic             win_r;
  logic             op_r;
  logic             full_r;
  logic             empty_r;
  logic [WIDTH-1:0] peek_r;
  logic             done0_r;
  logic             done1_r;
  logic             err_r;
  logic [WIDTH-1:0] dout_r;
  logic             stk_c_r;
  logic             stk_en_r;
  logic [WIDTH-1:0] stk_push_r;

  logic             win_s;
  logic             sel_op_s;
  logic [WIDTH-1:0] sel_din_s;
  logic             rej_s;
  logic             exec_rej_s;

  rr_pick u_rr_pick (
    .req0 (bus.req0),
    .req1 (bus.req1),
    .last (last_r),
    .win  (win_s)
  );

  // Operands of the would-be winner and the reject verdicts for ARB and EXEC.
  always_comb begin
    sel_op_s  = bus.op0;
    sel_din_s = bus.din0;
    if (win_s) begin
      sel_op_s  = bus.op1;
      sel_din_s = bus.din1;
    end else begin
      sel_op_s  = bus.op0;
      sel_din_s = bus.din0;
    end
    rej_s      = op_rejected(sel_op_s, bus.stk_full, bus.stk_empty);
    exec_rej_s = op_rejected(op_r, full_r, empty_r);
  end

  // Sequencer; stk_en is raised at the ARB edge so it is high exactly during EXEC.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_r    <= IDLE;
      last_r     <= 1'b1;
      win_r      <= 1'b0;
      op_r       <= OP_POP;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      peek_r     <= '0;
      done0_r    <= 1'b0;
      done1_r    <= 1'b0;
      err_r      <= 1'b0;
      dout_r     <= '0;
      stk_c_r    <= 1'b0;
      stk_en_r   <= 1'b0;
      stk_push_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done0_r <= 1'b0;
          done1_r <= 1'b0;
          if (bus.req0 || bus.req1) begin
            state_r <= ARB;
          end else begin
            state_r <= IDLE;
          end
        end
        ARB: begin
          win_r      <= win_s;
          op_r       <= sel_op_s;
          peek_r     <= bus.stk_peek;
          full_r     <= bus.stk_full;
          empty_r    <= bus.stk_empty;
          stk_c_r    <= sel_op_s;
          stk_push_r <= sel_din_s;
          stk_en_r   <= ~rej_s;
          state_r    <= EXEC;
        end
        EXEC: begin
          stk_en_r <= 1'b0;
          err_r    <= exec_rej_s;
          done0_r  <= (win_r == 1'b0);
          done1_r  <= (win_r == 1'b1);
          // The pre-pop top captured in ARB is what the requester receives.
          if (!exec_rej_s && op_r == OP_POP) begin
            dout_r <= peek_r;
          end else begin
            dout_r <= dout_r;
          end
          state_r <= RESP;
        end
        RESP: begin
          done0_r <= 1'b0;
          done1_r <= 1'b0;
          err_r   <= 1'b0;
          last_r  <= win_r;
          state_r <= IDLE;
        end
        default: begin
          stk_en_r <= 1'b0;
          done0_r  <= 1'b0;
          done1_r  <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.done0    = done0_r;
  assign bus.done1    = done1_r;
  assign bus.err      = err_r;
  assign bus.dout     = dout_r;
  assign bus.stk_c    = stk_c_r;
  assign bus.stk_en   = stk_en_r;
  assign bus.stk_push = stk_push_r;

endmodule

// File: tb/tb_stack_arbiter.sv
// Pairs stack_arbiter with a two-entry stack and checks it with directed vectors,
// hand-written corner sequences and a random run against a transaction-level model.
module tb_stack_arbiter;
  import stack_arbiter_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  stack_arbiter_if #(.WIDTH(W)) bus ();

  stack_arbiter #(.WIDTH(W), .DEPTH(1)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Two-entry stack; cleared together with the arbiter so every reset starts empty.
  logic [1:0]   cnt = 2'd0;
  logic [W-1:0] mem0, mem1;
  always @(posedge clk) begin
    if (!clr) begin
      cnt <= 2'd0;
    end else if (bus.stk_en && bus.stk_c && cnt != 2'd2) begin
      if (cnt == 2'd0) mem0 <= bus.stk_push;
      else mem1 <= bus.stk_push;
      cnt <= cnt + 2'd1;
    end else if (bus.stk_en && !bus.stk_c && cnt != 2'd0) begin
      cnt <= cnt - 2'd1;
    end
  end
  assign bus.stk_peek  = (cnt == 2'd2) ? mem1 : ((cnt == 2'd1) ? mem0 : '0);
  assign bus.stk_full  = (cnt == 2'd2);
  assign bus.stk_empty = (cnt == 2'd0);

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic set_req(input bit i, input bit r, input bit o, input logic [W-1:0] d);
    if (i) begin
      bus.req1 = r; bus.op1 = o; bus.din1 = d;
    end else begin
      bus.req0 = r; bus.op0 = o; bus.din0 = d;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
  endtask

  typedef struct packed {
    logic         who;
    logic         op;
    logic [W-1:0] din;
    logic         exp_err;
    logic [W-1:0] exp_dout;
    logic         exp_empty;
    logic         exp_full;
    logic [W-1:0] exp_peek;
  } vec_t;

  vec_t vecs [9];

  // One single-requester operation from IDLE, checking latency, stack strobe and response.
  task automatic run_vec(input vec_t v);
    int en_n, en_cyc, done_cyc;
    logic got_w, got_err, got_c;
    logic [W-1:0] got_data, got_dout;
    en_n = 0; en_cyc = 0; done_cyc = 0;
    got_w = 1'b0; got_err = 1'b0; got_c = 1'b0; got_data = '0; got_dout = '0;
    @(negedge clk);
    set_req(v.who, 1'b1, v.op, v.din);
    for (int k = 1; k <= 8 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (bus.stk_en) begin
        en_n++; en_cyc = k; got_c = bus.stk_c; got_data = bus.stk_push;
      end
      if (bus.done0 || bus.done1) begin
        done_cyc = k; got_w = bus.done1; got_err = bus.err; got_dout = bus.dout;
        set_req(v.who, 1'b0, 1'b0, 8'h00);
      end
    end
    check("vec_done_latency", 32'(done_cyc), 32'd3);
    check("vec_winner", 32'(got_w), 32'(v.who));
    check("vec_err", 32'(got_err), 32'(v.exp_err));
    check("vec_dout", 32'(got_dout), 32'(v.exp_dout));
    check("vec_en_count", 32'(en_n), v.exp_err ? 32'd0 : 32'd1);
    if (!v.exp_err) begin
      check("vec_en_latency", 32'(en_cyc), 32'd2);
      check("vec_stk_c", 32'(got_c), 32'(v.op));
      check("vec_stk_push", 32'(got_data), 32'(v.din));
    end
    check("vec_empty", 32'(bus.stk_empty), 32'(v.exp_empty));
    check("vec_full", 32'(bus.stk_full), 32'(v.exp_full));
    if (!v.exp_empty) check("vec_peek", 32'(bus.stk_peek), 32'(v.exp_peek));
  endtask

  // Transaction-level reference: a queue for the stack, who was served last, pending op.
  logic [W-1:0] q [$];
  bit           m_last, m_busy, m_win, m_op, m_acc;
  int           m_start, rel;
  logic [W-1:0] m_din, m_popv, m_dout;
  bit           hold [2];

  initial begin
    int k, nd, pulses;
    bit got_done;
    clr = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 8'h00);

    vecs[0] = '{1'b0, OP_PUSH, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{1'b1, OP_POP,  8'h00, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b1, OP_POP,  8'h00, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{1'b0, OP_PUSH, 8'h11, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h11};
    vecs[4] = '{1'b1, OP_PUSH, 8'h22, 1'b0, 8'hA5, 1'b0, 1'b1, 8'h22};
    vecs[5] = '{1'b0, OP_PUSH, 8'h33, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h22};
    vecs[6] = '{1'b1, OP_POP,  8'h00, 1'b0, 8'h22, 1'b0, 1'b0, 8'h11};
    vecs[7] = '{1'b0, OP_POP,  8'h00, 1'b0, 8'h11, 1'b1, 1'b0, 8'h00};
    vecs[8] = '{1'b0, OP_POP,  8'h00, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00};

    repeat (3) @(negedge clk);
    check("rst_done0", 32'(bus.done0), 32'd0);
    check("rst_done1", 32'(bus.done1), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_stk_en", 32'(bus.stk_en), 32'd0);
    check("rst_stk_c", 32'(bus.stk_c), 32'd0);
    check("rst_stk_push", 32'(bus.stk_push), 32'd0);
    clr = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Both requesters keep pushing: grants must alternate, starting with requester 0.
    do_reset();
    @(negedge clk);
    set_req(1'b0, 1'b1, OP_PUSH, 8'h01);
    set_req(1'b1, 1'b1, OP_PUSH, 8'h02);
    nd = 0; k = 0;
    while (nd < 4 && k < 40) begin
      @(negedge clk);
      k++;
      check("tie_exclusive", 32'(bus.done0 & bus.done1), 32'd0);
      if (bus.done0 || bus.done1) begin
        check("tie_winner", 32'(bus.done1), 32'(nd % 2));
        check("tie_cycle", 32'(k), 32'(3 + 4 * nd));
        check("tie_err", 32'(bus.err), 32'(nd >= 2));
        nd++;
      end
    end
    check("tie_count", 32'(nd), 32'd4);
    set_req(1'b0, 1'b0, 1'b0, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 8'h00);
    check("tie_full_peek", 32'(bus.stk_peek), 32'h02);
    check("tie_full_flag", 32'(bus.stk_full), 32'd1);

    // Reset landing on the EXEC cycle, then on the ARB cycle.
    do_reset();
    run_vec('{1'b0, OP_PUSH, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A});
    run_vec('{1'b1, OP_POP,  8'h00, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00});
    @(negedge clk);
    set_req(1'b0, 1'b1, OP_PUSH, 8'h77);
    k = 0;
    while (!bus.stk_en && k < 6) begin
      @(negedge clk);
      k++;
    end
    check("rexec_en_cycle", 32'(k), 32'd2);
    clr = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("rexec_done0", 32'(bus.done0), 32'd0);
    check("rexec_done1", 32'(bus.done1), 32'd0);
    check("rexec_err", 32'(bus.err), 32'd0);
    check("rexec_dout", 32'(bus.dout), 32'd0);
    check("rexec_stk_en", 32'(bus.stk_en), 32'd0);
    check("rexec_stk_c", 32'(bus.stk_c), 32'd0);
    check("rexec_stk_push", 32'(bus.stk_push), 32'd0);
    clr = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done0 || bus.done1 || bus.stk_en) pulses++;
    end
    check("rexec_no_retry", 32'(pulses), 32'd0);

    @(negedge clk);
    set_req(1'b1, 1'b1, OP_PUSH, 8'h44);
    @(negedge clk);
    clr = 1'b0;
    set_req(1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    clr = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done0 || bus.done1 || bus.stk_en) pulses++;
    end
    check("rarb_abort", 32'(pulses), 32'd0);
    check("rarb_empty", 32'(bus.stk_empty), 32'd1);

    set_req(1'b0, 1'b1, OP_PUSH, 8'h01);
    set_req(1'b1, 1'b1, OP_PUSH, 8'h02);
    k = 0; got_done = 1'b0;
    while (!got_done && k < 8) begin
      @(negedge clk);
      k++;
      if (bus.done0 || bus.done1) begin
        got_done = 1'b1;
        check("rst_first_tie_winner", 32'(bus.done1), 32'd0);
      end
    end
    check("rst_first_tie_done", 32'(got_done), 32'd1);
    set_req(1'b0, 1'b0, 1'b0, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 8'h00);

    // Random requesters against the reference model, cycle by cycle.
    do_reset();
    q.delete();
    m_last = 1'b1; m_busy = 1'b0; m_dout = '0; m_acc = 1'b0; m_op = 1'b0; m_win = 1'b0;
    m_din = '0; m_popv = '0; m_start = 0;
    hold[0] = 1'b0; hold[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rel = m_busy ? (c - m_start) : -1;
      if (rel == 3) begin
        m_last = m_win;
        if (m_acc && m_op == OP_POP) m_dout = m_popv;
      end
      check("rnd_stk_en", 32'(bus.stk_en), 32'(rel == 2 && m_acc));
      check("rnd_done0", 32'(bus.done0), 32'(rel == 3 && !m_win));
      check("rnd_done1", 32'(bus.done1), 32'(rel == 3 && m_win));
      check("rnd_done_exclusive", 32'(bus.done0 & bus.done1), 32'd0);
      check("rnd_dout", 32'(bus.dout), 32'(m_dout));
      if (rel == 2 && m_acc) begin
        check("rnd_stk_c", 32'(bus.stk_c), 32'(m_op));
        check("rnd_stk_push", 32'(bus.stk_push), 32'(m_din));
      end
      if (rel == 3) check("rnd_err", 32'(bus.err), 32'(!m_acc));

      for (int i = 0; i < 2; i++) begin
        got_done = (i == 1) ? bus.done1 : bus.done0;
        if (got_done) hold[i] = 1'b0;
        if (!hold[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            hold[i] = 1'b1;
            set_req(1'(i), 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
          end else begin
            set_req(1'(i), 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
          end
        end else if (rel == 2 && m_win == 1'(i) && $urandom_range(0, 1) == 1) begin
          set_req(1'(i), 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
        end
      end

      if (rel == 1) begin
        if (bus.req0 && bus.req1) m_win = !m_last;
        else m_win = bus.req1;
        m_op  = m_win ? bus.op1 : bus.op0;
        m_din = m_win ? bus.din1 : bus.din0;
        m_acc = m_op ? (q.size() < 2) : (q.size() > 0);
        if (m_acc) begin
          if (m_op) q.push_back(m_din);
          else m_popv = q.pop_back();
        end
      end
      if (!m_busy && (bus.req0 || bus.req1)) begin
        m_busy  = 1'b1;
        m_start = c;
      end
      if (rel == 3) m_busy = 1'b0;
    end
    set_req(1'b0, 1'b0, 1'b0, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, data width of the shared stack; DEPTH, default 1, log2 of the stack entry count.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 clr  in  1  synchronous, active-low reset; sampled only on the clk rising edge.
REQ-004 req0/req1  in  1 each  requester 0/1 operation request, held high until its done pulse.
REQ-005 op0/op1  in  1 each  1 = push, 0 = pop; valid while the matching req is high.
REQ-006 din0/din1  in  WIDTH each  push data; valid while the matching req is high.
REQ-007 done0/done1  out  1 each  one-cycle completion pulse to the granted requester.
REQ-008 err  out  1  valid with done; 1 = operation rejected (push when full, pop when empty).
REQ-009 dout  out  WIDTH  popped value; valid with done of a successful pop.
REQ-010 stk_c  out  1  stack control: 1 = push, 0 = pop.
REQ-011 stk_en  out  1  stack enable; high exactly one cycle per accepted operation.
REQ-012 stk_push  out  WIDTH  data driven to the stack.
REQ-013 stk_peek, stk_full, stk_empty  in  WIDTH, 1, 1  current stack top, full flag, empty flag.

Function
REQ-014 The FSM SHALL have the states IDLE, ARB, EXEC and RESP.
REQ-015 IDLE SHALL go to ARB when req0 or req1 is high, and SHALL otherwise stay in IDLE.
REQ-016 ARB SHALL latch the winner, its op and din, stk_peek, stk_full and stk_empty, then go to EXEC.
REQ-017 Arbitration SHALL be round-robin: a single request wins; when both request, the requester not served last wins.
REQ-018 The last-served pointer SHALL update only in RESP.
REQ-019 EXEC SHALL assert stk_en=1 with stk_c=op and stk_push=din for one cycle, unless the op is rejected; EXEC SHALL then go to RESP.
REQ-020 A push with latched stk_full=1 SHALL be rejected, with stk_en held 0.
REQ-021 A pop with latched stk_empty=1 SHALL be rejected, with stk_en held 0.
REQ-022 RESP SHALL pulse done of the winner for one cycle, drive err, and return to IDLE.
REQ-023 On a successful pop, dout SHALL equal the stk_peek value latched in ARB (the pre-pop top).
REQ-024 dout SHALL hold its value until the next successful pop.
REQ-025 Latency SHALL be: req high in IDLE at cycle n gives done at cycle n+3; stk_en, when issued, is at cycle n+2.
REQ-026 A requester still holding req in the cycle after its done SHALL be treated as a new request.
REQ-027 Changes to req, op or din after ARB SHALL NOT affect the operation in flight.
REQ-028 stk_en SHALL be 0 in IDLE, ARB and RESP, so the stack always presents a settled peek during ARB.
REQ-029 done0 and done1 SHALL never be high in the same cycle.
REQ-030 With DEPTH=1, full/empty handling SHALL need no special case; the flags come from the stack only.

Reset
REQ-031 On a clk edge with clr=0, the arbiter SHALL enter state IDLE and point last-served to 1, so requester 0 wins the first tie.
REQ-032 Reset SHALL drive done0=done1=0, err=0, dout=0, stk_en=0, stk_c=0 and stk_push=0.
REQ-033 Reset during ARB, EXEC or RESP SHALL abort the operation with no stk_en and no done pulse.
REQ-034 An operation aborted by reset SHALL NOT be retried automatically.

Structure
REQ-035 The shared package SHALL hold the FSM state encoding (IDLE=0, ARB=1, EXEC=2, RESP=3), the op encoding constants (OP_POP=0, OP_PUSH=1) and the default WIDTH/DEPTH values.
REQ-036 The arbiter SHALL contain no stack storage; it connects to one external stack instance.
REQ-037 One sub-module, rr_pick, SHALL be used: a two-way round-robin chooser taking req0, req1 and last and returning the winner index.
REQ-038 The top level SHALL be a testbench pairing stack_arbiter with the stack.

Verification
REQ-039 Single push: req0=1, op0=1, din0=8'hA5 on an empty stack -> stk_en at n+2 with stk_push=A5; done0 at n+3, err=0; stk_empty then 0.
REQ-040 Pop: after REQ-039, req1=1, op1=0 -> done1 at n+3 with dout=8'hA5, err=0; stk_empty returns to 1.
REQ-041 Tie: req0 and req1 both held, pushing 8'h01 and 8'h02 -> grants alternate 0,1,0,1; done pulses never overlap.
REQ-042 Errors: pop on empty -> done with err=1 and no stk_en; fill to full, then push 8'h33 -> err=1 and stack contents unchanged.
REQ-043 Reset in EXEC: clr=0 in the stk_en cycle -> next cycle IDLE with all outputs 0, no done pulse; first tie after reset goes to requester 0.
